// File: rtl/mdu_sequencer_pkg.sv
// mdu_sequencer_pkg
//   Shared types for the multiply/divide sequencer: operation codes
//   presented on md_op, FSM state codes, and small operation-class helpers.
package mdu_sequencer_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic is_mul(input md_op_e op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic is_div(input md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if
//   E-stage <-> MDU connection.
//   master (pipeline side): drives start, md_op, A, B, flush, md_in_d;
//                           observes busy, stall, HI, LO.
//   slave  (sequencer)    : the mirror image.
interface mdu_sequencer_if;
   import mdu_sequencer_pkg::*;

   logic        start;
   md_op_e      md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        flush;
   logic        md_in_d;
   logic        busy;
   logic        stall;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output start, md_op, A, B, flush, md_in_d,
      input  busy, stall, HI, LO
   );

   modport slave (
      input  start, md_op, A, B, flush, md_in_d,
      output busy, stall, HI, LO
   );

endinterface

// File: rtl/mdu_sequencer_arith.sv
// mdu_arith
//   Combinational arithmetic core of the sequencer.
//   op            : operation code
//   a, b          : rs / rt operands
//   hi_cur/lo_cur : current architectural HI/LO (returned on divide by zero
//                   and for non-arithmetic ops)
//   res_hi/res_lo : 64-bit product, or remainder/quotient
module mdu_arith
   import mdu_sequencer_pkg::*;
(
   input  md_op_e      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi_cur,
   input  logic [31:0] lo_cur,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic signed [63:0] s_prod;
   logic        [63:0] u_prod;
   logic        [31:0] mag_a, mag_b, mag_q, mag_r;
   logic        [31:0] u_q, u_r;
   logic               sgn_a, sgn_b;

   always_comb begin
      s_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      u_prod = {32'd0, a} * {32'd0, b};

      // Signed divide on magnitudes: truncation toward zero, remainder follows
      // the dividend. 0x80000000/-1 falls out as q=0x80000000, r=0 because the
      // magnitude 2^31 is representable unsigned and negating it wraps back.
      sgn_a = a[31];
      sgn_b = b[31];
      mag_a = sgn_a ? (32'd0 - a) : a;
      mag_b = sgn_b ? (32'd0 - b) : b;

      // Zero divisor never reaches a divider so no X propagates.
      if (b == 32'd0) begin
         mag_q = 32'd0;
         mag_r = 32'd0;
         u_q   = 32'd0;
         u_r   = 32'd0;
      end else begin
         mag_q = mag_a / mag_b;
         mag_r = mag_a % mag_b;
         u_q   = a / b;
         u_r   = a % b;
      end

      res_hi = hi_cur;
      res_lo = lo_cur;
      case (op)
         MD_MULT:  {res_hi, res_lo} = s_prod;
         MD_MULTU: {res_hi, res_lo} = u_prod;
         MD_DIV: begin
            if (b != 32'd0) begin
               res_lo = (sgn_a ^ sgn_b) ? (32'd0 - mag_q) : mag_q;
               res_hi = sgn_a ? (32'd0 - mag_r) : mag_r;
            end
         end
         MD_DIVU: begin
            if (b != 32'd0) begin
               res_lo = u_q;
               res_hi = u_r;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
//   E-stage multiply/divide sequencer. Computes a result at start, holds it
//   in pending registers while a busy counter models the unit latency, then
//   commits it to HI/LO. MTHI/MTLO write HI/LO directly in one edge.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   mdu   : slave side of mdu_sequencer_if (start/md_op/A/B/flush/md_in_d
//           in; busy/stall/HI/LO out)
module mdu_sequencer
   import mdu_sequencer_pkg::*;
#(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   mdu_sequencer_if.slave   mdu
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic [31:0]        pend_hi_q, pend_hi_d;
   logic [31:0]        pend_lo_q, pend_lo_d;
   logic [31:0]        ar_hi, ar_lo;

   mdu_arith u_arith (
      .op     (mdu.md_op),
      .a      (mdu.A),
      .b      (mdu.B),
      .hi_cur (hi_q),
      .lo_cur (lo_q),
      .res_hi (ar_hi),
      .res_lo (ar_lo)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;

      case (state_q)
         ST_IDLE: begin
            if (mdu.start && !mdu.flush) begin
               if (is_mul(mdu.md_op) || is_div(mdu.md_op)) begin
                  pend_hi_d = ar_hi;
                  pend_lo_d = ar_lo;
                  cnt_d     = is_mul(mdu.md_op) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
                  state_d   = ST_RUN;
               end else if (mdu.md_op == MD_MTHI) begin
                  hi_d = mdu.A;
               end else if (mdu.md_op == MD_MTLO) begin
                  lo_d = mdu.A;
               end
            end
         end
         ST_RUN: begin
            // A committed op ignores flush and any stray start.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

   assign mdu.busy  = (state_q == ST_RUN);
   // start term stalls D during the cycle an op is entering RUN.
   assign mdu.stall = mdu.md_in_d & (mdu.start | mdu.busy);
   assign mdu.HI    = hi_q;
   assign mdu.LO    = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer
//   Directed bench for mdu_sequencer. Inputs change 1 time unit after each
//   rising edge; outputs are sampled at that same point (or after a short
//   settle for the combinational stall).
module tb_mdu_sequencer;
   import mdu_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_assert = 0;
   int   n_fail   = 0;

   mdu_sequencer_if bus ();

   mdu_sequencer #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic fl, input logic mdd);
      bus.start   = st;
      bus.md_op   = op;
      bus.A       = a;
      bus.B       = b;
      bus.flush   = fl;
      bus.md_in_d = mdd;
   endtask

   task automatic quiet();
      drive(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   // Pulse start for one cycle, then expect busy for n cycles and idle after.
   task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input int n);
      drive(1'b1, op, a, b, 1'b0, 1'b0);
      tick();
      quiet();
      for (int i = 1; i <= n; i++) begin
         chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
         tick();
      end
      chk({tag, "_done"}, {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      quiet();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_hi", bus.HI, 32'd0);
      chk("rst_lo", bus.LO, 32'd0);
      bus.md_in_d = 1'b1;
      #1;
      chk("idle_nostall", {31'd0, bus.stall}, 32'd0);
      quiet();

      // 1. MULT -3 * 7 = -21
      run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, 5);
      chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
      chk("mult_lo", bus.LO, 32'hFFFF_FFEB);

      // 2. DIVU 100 / 7
      run_op("divu", MD_DIVU, 32'd100, 32'd7, 10);
      chk("divu_lo", bus.LO, 32'd14);
      chk("divu_hi", bus.HI, 32'd2);

      // 3. DIV by zero leaves HI/LO alone
      drive(1'b1, MD_MTHI, 32'h11, 32'd0, 1'b0, 1'b0);
      tick();
      chk("mthi_hi", bus.HI, 32'h11);
      chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
      drive(1'b1, MD_MTLO, 32'h22, 32'd0, 1'b0, 1'b0);
      tick();
      chk("mtlo_lo", bus.LO, 32'h22);
      run_op("div0", MD_DIV, 32'd5, 32'd0, 10);
      chk("div0_hi", bus.HI, 32'h11);
      chk("div0_lo", bus.LO, 32'h22);

      // 4. MULTU with a D-stage HI/LO user in cycles 0..3
      drive(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1);
      #1;
      chk("stall_c0", {31'd0, bus.stall}, 32'd1);
      tick();
      drive(1'b0, MD_MULT, 32'd0, 32'd0, 1'b0, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         chk("stall_c1_3", {31'd0, bus.stall}, 32'd1);
         tick();
      end
      bus.md_in_d = 1'b0;
      #1;
      chk("stall_off", {31'd0, bus.stall}, 32'd0);
      chk("multu_busy4", {31'd0, bus.busy}, 32'd1);
      tick();
      chk("multu_busy5", {31'd0, bus.busy}, 32'd1);
      tick();
      chk("multu_done", {31'd0, bus.busy}, 32'd0);
      chk("multu_hi", bus.HI, 32'd1);
      chk("multu_lo", bus.LO, 32'hFFFF_FFFE);

      // 5. Flushed start does nothing; MTLO right after works
      drive(1'b1, MD_MULT, 32'd9, 32'd9, 1'b1, 1'b0);
      tick();
      chk("flush_busy", {31'd0, bus.busy}, 32'd0);
      chk("flush_hi", bus.HI, 32'd1);
      chk("flush_lo", bus.LO, 32'hFFFF_FFFE);
      drive(1'b1, MD_MTLO, 32'h1234, 32'd0, 1'b0, 1'b0);
      tick();
      quiet();
      chk("mtlo2_lo", bus.LO, 32'h1234);
      chk("mtlo2_busy", {31'd0, bus.busy}, 32'd0);
      chk("mtlo2_hi", bus.HI, 32'd1);

      // Signed divide sign rules and overflow
      run_op("divs", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10);
      chk("divs_lo", bus.LO, 32'hFFFF_FFFD);
      chk("divs_hi", bus.HI, 32'hFFFF_FFFF);
      run_op("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
      chk("divovf_lo", bus.LO, 32'h8000_0000);
      chk("divovf_hi", bus.HI, 32'd0);

      // Stray start during RUN is ignored
      drive(1'b1, MD_MULT, 32'd6, 32'd7, 1'b0, 1'b0);
      tick();
      quiet();
      chk("stray_busy1", {31'd0, bus.busy}, 32'd1);
      drive(1'b1, MD_DIVU, 32'd9, 32'd2, 1'b0, 1'b0);
      tick();
      quiet();
      for (int c = 2; c <= 5; c++) begin
         chk("stray_busy", {31'd0, bus.busy}, 32'd1);
         tick();
      end
      chk("stray_done", {31'd0, bus.busy}, 32'd0);
      chk("stray_lo", bus.LO, 32'd42);
      chk("stray_hi", bus.HI, 32'd0);

      // 6. Reset mid-DIV aborts with no late writeback
      drive(1'b1, MD_DIV, 32'd100, 32'd3, 1'b0, 1'b0);
      tick();
      quiet();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst6_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst6_hi", bus.HI, 32'd0);
      chk("rst6_lo", bus.LO, 32'd0);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("rst6_idle", {31'd0, bus.busy}, 32'd0);
      end
      chk("rst6_hi_late", bus.HI, 32'd0);
      chk("rst6_lo_late", bus.LO, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
